// File: rtl/ll_dequeue_scheduler_if.sv
// Bundle between ll_dequeue_scheduler, its upstream linked_list_fifo and the downstream consumer.
// Latency: none; wires only.
// Backpressure: out_ready from the consumer; pop is the only flow control toward the FIFO.
interface ll_dequeue_scheduler_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
);
    // upstream (linked_list_fifo) side
    logic [NUM_FIFOS-1:0] empty;
    logic [WIDTH-1:0]     ll_data_out;
    logic                 pop;
    logic [SEL_WIDTH-1:0] pop_sel;
    // downstream (consumer) side
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_WIDTH-1:0] out_sel;

    // scheduler view
    modport master (
        input  empty, ll_data_out, out_ready,
        output pop, pop_sel, out_valid, out_data, out_sel
    );

    // environment view (FIFO model + consumer)
    modport slave (
        output empty, ll_data_out, out_ready,
        input  pop, pop_sel, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/ll_dequeue_scheduler.sv
// Round-robin pop from linked_list_fifo into a 2-entry tagged skid buffer (DEQ_STRICT_PRIO_EN: fixed priority, queue 0 first).
// Latency: item popped in cycle N is on out_* in N+1 when the buffer is empty; 1 item/cycle sustained.
// Backpressure: out_ready low fills the buffer; cnt==2 blocks pop, with no combinational out_ready->pop path.
module ll_dequeue_scheduler #(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ll_dequeue_scheduler_if.master bus
);
    logic [WIDTH-1:0]     buf_dat [2];
    logic [SEL_WIDTH-1:0] buf_sel [2];
    logic                 rd_idx;
    logic                 wr_idx;
    logic [1:0]           cnt;

    logic                 space;
    logic                 any_elig;
    logic                 drain;
    logic [SEL_WIDTH-1:0] gnt;

    // space looks only at registered occupancy so out_ready never reaches pop
    assign space = (cnt != 2'd2);
    assign drain = bus.out_valid & bus.out_ready;

`ifdef DEQ_STRICT_PRIO_EN
    // Fixed priority: the lowest-index non-empty queue wins (descending scan, last hit kept).
    always_comb begin
        any_elig = 1'b0;
        gnt      = '0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (!bus.empty[SEL_WIDTH'(i)]) begin
                any_elig = 1'b1;
                gnt      = SEL_WIDTH'(i);
            end
        end
    end
`else
    logic [SEL_WIDTH-1:0] rr_ptr;
    int                   idx;

    // Round-robin: first non-empty queue at or after rr_ptr; wrap is explicit so NUM_FIFOS need not be 2^n.
    always_comb begin
        any_elig = 1'b0;
        gnt      = '0;
        idx      = 0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_FIFOS) begin
                idx = idx - NUM_FIFOS;
            end
            if (!bus.empty[SEL_WIDTH'(idx)]) begin
                any_elig = 1'b1;
                gnt      = SEL_WIDTH'(idx);
            end
        end
    end

    // Pointer moves past the granted queue only when a pop actually happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (bus.pop) begin
            rr_ptr <= (gnt == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : gnt + 1'b1;
        end
    end
`endif

    // rst gates pop directly so the FIFO never sees a pop while held in reset.
    assign bus.pop     = space & any_elig & rst;
    assign bus.pop_sel = bus.pop ? gnt : '0;

    // Skid buffer: capture the popped head with its queue tag, retire the oldest entry on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_dat[0] <= '0;
            buf_dat[1] <= '0;
            buf_sel[0] <= '0;
            buf_sel[1] <= '0;
            rd_idx     <= 1'b0;
            wr_idx     <= 1'b0;
            cnt        <= 2'd0;
        end else begin
            if (bus.pop) begin
                buf_dat[wr_idx] <= bus.ll_data_out;
                buf_sel[wr_idx] <= gnt;
                wr_idx          <= ~wr_idx;
            end
            if (drain) begin
                rd_idx <= ~rd_idx;
            end
            case ({bus.pop, drain})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Oldest entry is presented straight from the buffer registers; it cannot change while unaccepted.
    assign bus.out_valid = (cnt != 2'd0);
    assign bus.out_data  = buf_dat[rd_idx];
    assign bus.out_sel   = buf_sel[rd_idx];
endmodule

// File: tb/tb_ll_dequeue_scheduler.sv
// Bench for ll_dequeue_scheduler: queue-based FIFO environment plus an in-order scoreboard model.
// Latency: checks one-cycle pop-to-output and 1 item/cycle streaming.
// Backpressure: drives out_ready low in directed and random phases.
module tb_ll_dequeue_scheduler;
    localparam int WIDTH     = 8;
    localparam int NUM_FIFOS = 2;
    localparam int SEL_WIDTH = 1;
    localparam int IW        = SEL_WIDTH + WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ll_dequeue_scheduler_if #(.WIDTH(WIDTH), .NUM_FIFOS(NUM_FIFOS), .SEL_WIDTH(SEL_WIDTH)) bus ();

    ll_dequeue_scheduler #(.WIDTH(WIDTH), .NUM_FIFOS(NUM_FIFOS), .SEL_WIDTH(SEL_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // upstream FIFO model: head of the selected queue presented combinationally
    logic [WIDTH-1:0] heads [NUM_FIFOS];
    assign bus.ll_data_out = heads[bus.pop_sel];

    logic [WIDTH-1:0]     q0 [$];
    logic [WIDTH-1:0]     q1 [$];
    logic [IW-1:0]        sb [$];
    logic [IW-1:0]        out_log [$];
    logic [SEL_WIDTH-1:0] sel_log [$];
    int                   nxt;
    int                   checks = 0;
    int                   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [WIDTH-1:0] qhead(input int c);
        if (c == 0) return (q0.size() != 0) ? q0[0] : '0;
        return (q1.size() != 0) ? q1[0] : '0;
    endfunction

    task automatic drive_upstream();
        bus.empty = {(q1.size() == 0), (q0.size() == 0)};
        heads[0]  = qhead(0);
        heads[1]  = qhead(1);
    endtask

    task automatic clear_logs();
        sel_log.delete();
        out_log.delete();
    endtask

    // One cycle, entered and left at a negedge. Inputs were set by the caller.
    task automatic step();
        bit                   any;
        int                   g;
        bit                   exp_pop;
        bit                   exp_vld;
        logic [IW-1:0]        exp_item;
        logic                 obs_pop;
        logic [SEL_WIDTH-1:0] obs_sel;
        logic                 obs_vld;
        logic                 rdy;
        logic [IW-1:0]        obs_item;
        drive_upstream();
        #1;
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            int c;
`ifdef DEQ_STRICT_PRIO_EN
            c = k;
`else
            c = (nxt + k) % NUM_FIFOS;
`endif
            if (!any && qsize(c) > 0) begin
                any = 1'b1;
                g   = c;
            end
        end
        exp_pop  = any && (sb.size() < 2);
        exp_vld  = (sb.size() > 0);
        exp_item = {SEL_WIDTH'(g), qhead(g)};

        check("pop", 32'(bus.pop), 32'(exp_pop));
        if (exp_pop) check("pop_sel", 32'(bus.pop_sel), 32'(g));
        if (bus.pop) check("pop_legal", 32'(bus.empty[bus.pop_sel]), 0);
        check("out_valid", 32'(bus.out_valid), 32'(exp_vld));
        if (exp_vld) check("out_item", 32'({bus.out_sel, bus.out_data}), 32'(sb[0]));

        obs_pop  = bus.pop;
        obs_sel  = bus.pop_sel;
        obs_vld  = bus.out_valid;
        rdy      = bus.out_ready;
        obs_item = {bus.out_sel, bus.out_data};
        if (obs_pop) sel_log.push_back(obs_sel);
        if (obs_vld && rdy) out_log.push_back(obs_item);

        @(posedge clk);
        // environment removes whatever the DUT actually popped
        if (obs_pop) begin
            if (obs_sel == 1'b0 && q0.size() != 0) q0.delete(0);
            else if (obs_sel == 1'b1 && q1.size() != 0) q1.delete(0);
        end
        // reference model advances on its own decisions
        if (exp_vld && rdy) sb.delete(0);
        if (exp_pop) begin
            sb.push_back(exp_item);
            nxt = (g + 1) % NUM_FIFOS;
        end
        @(negedge clk);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.empty     = '1;
        heads[0]      = '0;
        heads[1]      = '0;
        nxt           = 0;

        // reset with all queues empty
        repeat (10) begin
            @(negedge clk);
            #1;
            check("rst_pop", 32'(bus.pop), 0);
            check("rst_out_valid", 32'(bus.out_valid), 0);
            check("rst_out_data", 32'(bus.out_data), 0);
            check("rst_out_sel", 32'(bus.out_sel), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // both queues hold 3 items, consumer always ready
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'(32'hA0 + i));
            q1.push_back(8'(32'hB0 + i));
        end
        bus.out_ready = 1'b1;
        clear_logs();
        repeat (9) step();
`ifndef DEQ_STRICT_PRIO_EN
        check("rr_pop_count", 32'(sel_log.size()), 6);
        for (int i = 0; i < 6 && i < sel_log.size(); i++)
            check("rr_sel_order", 32'(sel_log[i]), 32'(i % 2));
        check("rr_out_count", 32'(out_log.size()), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++)
            check("rr_out_order", 32'(out_log[i]),
                  (i % 2 == 0) ? 32'(32'h0A0 + i / 2) : 32'(32'h1B0 + i / 2));
`endif

        // only queue 1 has an item while the pointer sits at queue 0
        q1.push_back(8'hC1);
        clear_logs();
        repeat (3) step();
        check("lone_q1_pops", 32'(sel_log.size()), 1);
        if (sel_log.size() > 0) check("lone_q1_sel", 32'(sel_log[0]), 1);
        if (out_log.size() > 0) check("lone_q1_out", 32'(out_log[0]), 32'h1C1);
        // pointer wrapped back to 0: queue 0 wins next
        q0.push_back(8'hD0);
        q1.push_back(8'hD1);
        clear_logs();
        repeat (4) step();
        if (sel_log.size() > 0) check("wrap_first_sel", 32'(sel_log[0]), 0);

        // backpressure: consumer stalled, queue 0 holds 4 items
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) q0.push_back(8'(32'hE0 + i));
        clear_logs();
        repeat (6) step();
        check("full_pop_count", 32'(sel_log.size()), 2);
        check("full_q0_left", 32'(q0.size()), 2);
        bus.out_ready = 1'b1;
        repeat (6) step();
        check("full_out_count", 32'(out_log.size()), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            check("full_out_order", 32'(out_log[i]), 32'(32'hE0 + i));

        // asynchronous reset with the buffer full and pointer past queue 0
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) q0.push_back(8'(32'hF0 + i));
        repeat (4) step();
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_pop", 32'(bus.pop), 0);
        check("arst_out_data", 32'(bus.out_data), 0);
        q0.delete();
        q1.delete();
        sb.delete();
        nxt = 0;
        q0.push_back(8'h90);
        q1.push_back(8'h91);
        drive_upstream();
        repeat (3) begin
            @(negedge clk);
            #1;
            check("in_rst_pop", 32'(bus.pop), 0);
            check("in_rst_out_valid", 32'(bus.out_valid), 0);
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        clear_logs();
        repeat (4) step();
        if (sel_log.size() > 0) check("post_rst_first_sel", 32'(sel_log[0]), 0);
        if (out_log.size() > 0) check("post_rst_first_out", 32'(out_log[0]), 32'h090);

`ifdef DEQ_STRICT_PRIO_EN
        // fixed priority: queue 0 is drained before queue 1 is touched
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'(32'h50 + i));
            q1.push_back(8'(32'h60 + i));
        end
        clear_logs();
        repeat (10) step();
        check("prio_pop_count", 32'(sel_log.size()), 6);
        for (int i = 0; i < 6 && i < sel_log.size(); i++)
            check("prio_sel_order", 32'(sel_log[i]), (i < 3) ? 0 : 1);
`endif

        // random traffic and random backpressure
        repeat (1500) begin
            if ($urandom_range(2) == 0 && q0.size() < 6) q0.push_back(8'($urandom));
            if ($urandom_range(2) == 0 && q1.size() < 6) q1.push_back(8'($urandom));
            bus.out_ready = ($urandom_range(3) != 0);
            step();
        end
        bus.out_ready = 1'b1;
        repeat (20) step();
        check("drain_empty", 32'(q0.size() + q1.size() + sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ll_dequeue_scheduler.md
Name: ll_dequeue_scheduler

Overview:
- Sits directly downstream of the shared linked-list FIFO (linked_list_fifo).
- Arbitrates round-robin among its non-empty queues and drives pop/pop_sel into it.
- Captures the popped head data into a 2-entry output skid buffer, tagged with the source queue id.
- Presents the tagged data to the consumer on a valid/ready handshake at up to one item per cycle.

Parameters:
- WIDTH, 8, data word width; matches linked_list_fifo WIDTH.
- NUM_FIFOS, 2, number of logical queues in the shared FIFO.
- SEL_WIDTH, $clog2(NUM_FIFOS), queue-select width.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
- empty  input  NUM_FIFOS  per-queue empty flags from linked_list_fifo.
- ll_data_out  input  WIDTH  head data of queue pop_sel; valid combinationally in the cycle pop is high.
- pop  output  1  pop strobe to linked_list_fifo.
- pop_sel  output  SEL_WIDTH  queue being popped; meaningful only when pop=1.
- out_valid  output  1  output buffer holds an item.
- out_ready  input  1  consumer accepts the item this cycle.
- out_data  output  WIDTH  data of the oldest buffered item.
- out_sel  output  SEL_WIDTH  source queue of the oldest buffered item.

Behaviour:
- State:
  - rr_ptr (SEL_WIDTH bits): highest-priority queue for the next grant.
  - buf[0:1] entries {sel, data}, with rd_idx (1 bit), wr_idx (1 bit) and cnt (2 bits, range 0..2).
- Reset (rst=0, async):
  - rr_ptr=0, cnt=0, rd_idx=wr_idx=0.
  - out_valid=0, out_data=0, out_sel=0.
  - pop forced to 0 while rst=0, combinationally.
- Eligibility: queue q is eligible iff empty[q]=0.
- Space: space = (cnt<2). Decided on registered cnt only; there is no combinational path from out_ready to pop.
- Grant (combinational):
  - g = first eligible queue scanning rr_ptr, rr_ptr+1, ... with wrap at NUM_FIFOS. Wrap is explicit, so NUM_FIFOS need not be a power of 2.
  - pop = space & any_eligible & rst.
  - pop_sel = g when pop=1, else 0.
- Pop legality: pop is never asserted for a queue whose empty flag is 1. This satisfies the shared FIFO's environmental assumption.
- Capture: on a posedge with pop=1:
  - buf[wr_idx] <= {g, ll_data_out}.
  - wr_idx toggles.
  - rr_ptr <= (g==NUM_FIFOS-1) ? 0 : g+1.
- Drain:
  - out_valid = (cnt!=0).
  - out_data/out_sel = buf[rd_idx].
  - On a posedge with out_valid & out_ready, rd_idx toggles.
  - out_data/out_sel are held stable while out_valid=1 and out_ready=0.
- Count:
  - cnt <= cnt + pop - (out_valid & out_ready).
  - Simultaneous pop and drain leaves cnt unchanged.
  - Sustained 1 item/cycle when out_ready stays high (steady state cnt=1).
- Latency: item popped in cycle N appears on out_* in cycle N+1 when the buffer was empty.
- Full: cnt=2 blocks pop regardless of out_ready; pop resumes the cycle after a drain.
- No eligible queue: pop=0 and rr_ptr holds.
- Push into an empty queue in cycle N is only visible via empty in N+1; the scheduler never looks ahead.
- rr_ptr advances only on a grant. Fairness: each continuously non-empty queue is granted at least once every NUM_FIFOS grants.
- Reset mid-operation: buffered items are discarded and not re-delivered. The upstream FIFO is reset by the same rst.

Optional Feature:
- Macro: DEQ_STRICT_PRIO_EN.
- Defined: grant is the lowest-index eligible queue (queue 0 highest priority); rr_ptr is not implemented and out_sel ordering follows priority.
- Undefined: round-robin arbitration exactly as in Behaviour.

Test Plan:
- Reset, all empty=1'b1 -> pop=0, out_valid=0, out_data=0, out_sel=0 for 10 cycles.
- NUM_FIFOS=2; queues 0 and 1 both hold 3 items (0xA0..0xA2, 0xB0..0xB2); out_ready=1 -> pop_sel alternates 0,1,0,1,0,1; out stream A0,B0,A1,B1,A2,B2 at 1 item/cycle.
- out_ready=0, queue 0 holds 4 items -> exactly 2 pops, cnt=2, then pop=0. Raise out_ready -> remaining 2 items delivered in order with no loss or duplication.
- Only queue 1 non-empty (1 item) with rr_ptr=0 -> pop_sel=1 in the first eligible cycle, out_sel=1 next cycle, then rr_ptr=0.
- Drive rst low mid-stream with cnt=2 -> out_valid=0 immediately (asynchronous), pop=0; after release, next grant starts from queue 0.
- DEQ_STRICT_PRIO_EN defined, both queues continuously non-empty -> pop_sel=0 every cycle until queue 0 empties, then queue 1 is served.
